wb_select_stage: RTL and testbench

- Parametrised successor to the combinational GRF write-back select logic.
- Registers one instruction's write-back controls and candidate data at a pipeline boundary, used at either the E/M or the M/W stage.
- Resolves the GRF write address (A3), write data (WD) and write enable from the registered controls.
- Tracks each instruction's Tnew countdown and exposes a forwarding/hazard interface, so stall/forward decisions come from one source.
- Supports stall, flush and an arbitrary number of WD sources.

---
 rtl/wb_select_stage.sv | 134 +++++++++++++
 tb/tb_wb_select_stage.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/wb_select_stage.sv
// rtl/wb_select_stage.sv - registered GRF write-back select with Tnew countdown and forwarding view
module wb_select_stage #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NSRC     = 4,
    parameter int SEL_W    = 2,
    parameter int LINK_REG = 31,
    parameter int TNEW_W   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [1:0]             in_a3_mode,
    input  logic [ADDR_W-1:0]      in_rt,
    input  logic [ADDR_W-1:0]      in_rd,
    input  logic [SEL_W-1:0]       in_wd_sel,
    input  logic [NSRC*DATA_W-1:0] in_src,
    input  logic [31:0]            in_pc,
    input  logic [TNEW_W-1:0]      in_tnew,
    output logic                   grf_we,
    output logic [ADDR_W-1:0]      grf_a3,
    output logic [DATA_W-1:0]      grf_wd,
    output logic [31:0]            grf_pc,
    output logic [ADDR_W-1:0]      fwd_a3,
    output logic                   fwd_ready,
    output logic [DATA_W-1:0]      fwd_data,
    output logic [TNEW_W-1:0]      tnew_out
);

    localparam logic [1:0]        MODE_RT   = 2'd0;
    localparam logic [1:0]        MODE_RD   = 2'd1;
    localparam logic [1:0]        MODE_LINK = 2'd2;
    localparam logic [1:0]        MODE_NONE = 2'd3;
    localparam logic [ADDR_W-1:0] LINK_A3   = ADDR_W'(LINK_REG);

    logic                   valid_q, valid_d;
    logic [1:0]             mode_q, mode_d;
    logic [ADDR_W-1:0]      rt_q, rt_d;
    logic [ADDR_W-1:0]      rd_q, rd_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [NSRC*DATA_W-1:0] src_q, src_d;
    logic [31:0]            pc_q, pc_d;
    logic [TNEW_W-1:0]      tnew_q, tnew_d;

    // Next state: flush beats capture; a stall holds everything but lets Tnew count down.
    always_comb begin
        valid_d = valid_q;
        mode_d  = mode_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        sel_d   = sel_q;
        src_d   = src_q;
        pc_d    = pc_q;
        tnew_d  = (tnew_q != '0) ? tnew_q - TNEW_W'(1) : '0;
        if (flush) begin
            valid_d = 1'b0;
            mode_d  = MODE_NONE;
            rt_d    = '0;
            rd_d    = '0;
            sel_d   = '0;
            src_d   = '0;
            pc_d    = '0;
            tnew_d  = '0;
        end else if (en) begin
            valid_d = in_valid;
            mode_d  = in_a3_mode;
            rt_d    = in_rt;
            rd_d    = in_rd;
            sel_d   = in_wd_sel;
            src_d   = in_src;
            pc_d    = in_pc;
            tnew_d  = in_tnew;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            mode_q  <= MODE_NONE;
            rt_q    <= '0;
            rd_q    <= '0;
            sel_q   <= '0;
            src_q   <= '0;
            pc_q    <= '0;
            tnew_q  <= '0;
        end else begin
            valid_q <= valid_d;
            mode_q  <= mode_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            sel_q   <= sel_d;
            src_q   <= src_d;
            pc_q    <= pc_d;
            tnew_q  <= tnew_d;
        end
    end

    logic [ADDR_W-1:0] a3;
    logic [DATA_W-1:0] wd;

    always_comb begin
        a3 = '0;
        if (valid_q) begin
            case (mode_q)
                MODE_RT:   a3 = rt_q;
                MODE_RD:   a3 = rd_q;
                MODE_LINK: a3 = LINK_A3;
                default:   a3 = '0;
            endcase
        end
    end

    // Select values at or beyond NSRC have no source and read as zero.
    always_comb begin
        wd = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (int'(sel_q) == k) begin
                wd = src_q[k*DATA_W +: DATA_W];
            end
        end
    end

    assign grf_a3    = a3;
    assign grf_wd    = wd;
    assign grf_we    = valid_q && (a3 != '0) && (tnew_q == '0);
    assign grf_pc    = pc_q;
    assign fwd_a3    = a3;
    assign fwd_ready = grf_we;
    assign fwd_data  = wd;
    assign tnew_out  = tnew_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// tb/tb_wb_select_stage.sv - directed checks of wb_select_stage, including a 3-source instance
module tb_wb_select_stage;

    logic        clk = 1'b0;
    logic        reset, en, flush, in_valid;
    logic [1:0]  in_a3_mode;
    logic [4:0]  in_rt, in_rd;
    logic [1:0]  in_wd_sel;
    logic [127:0] in_src;
    logic [95:0]  in_src3;
    logic [31:0] in_pc;
    logic [1:0]  in_tnew;

    logic        grf_we, fwd_ready, grf_we3, fwd_ready3;
    logic [4:0]  grf_a3, fwd_a3, grf_a33, fwd_a33;
    logic [31:0] grf_wd, grf_pc, fwd_data, grf_wd3, grf_pc3, fwd_data3;
    logic [1:0]  tnew_out, tnew_out3;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_select_stage dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
        .in_a3_mode(in_a3_mode), .in_rt(in_rt), .in_rd(in_rd), .in_wd_sel(in_wd_sel),
        .in_src(in_src), .in_pc(in_pc), .in_tnew(in_tnew),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
        .fwd_a3(fwd_a3), .fwd_ready(fwd_ready), .fwd_data(fwd_data), .tnew_out(tnew_out)
    );

    wb_select_stage #(.NSRC(3)) dut3 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
        .in_a3_mode(in_a3_mode), .in_rt(in_rt), .in_rd(in_rd), .in_wd_sel(in_wd_sel),
        .in_src(in_src3), .in_pc(in_pc), .in_tnew(in_tnew),
        .grf_we(grf_we3), .grf_a3(grf_a33), .grf_wd(grf_wd3), .grf_pc(grf_pc3),
        .fwd_a3(fwd_a33), .fwd_ready(fwd_ready3), .fwd_data(fwd_data3), .tnew_out(tnew_out3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input string tag, input logic we, input logic [4:0] a3,
                            input logic [31:0] wd, input logic [1:0] tn);
        chk({tag, ".we"},    32'(grf_we),    32'(we));
        chk({tag, ".a3"},    32'(grf_a3),    32'(a3));
        chk({tag, ".wd"},    grf_wd,         wd);
        chk({tag, ".fa3"},   32'(fwd_a3),    32'(a3));
        chk({tag, ".frdy"},  32'(fwd_ready), 32'(we));
        chk({tag, ".fdata"}, fwd_data,       wd);
        chk({tag, ".tnew"},  32'(tnew_out),  32'(tn));
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b1;
        in_a3_mode = 2'd1; in_rt = 5'd3; in_rd = 5'd8; in_wd_sel = 2'd0;
        in_src  = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        in_src3 = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        in_pc = 32'h0000_3000; in_tnew = 2'd3;
        step();
        step();
        chk_main("reset", 1'b0, 5'd0, 32'h0, 2'd0);
        chk("reset.pc", grf_pc, 32'h0);
        chk("reset.we3", 32'(grf_we3), 32'h0);

        // rd-mode capture with zero Tnew writes immediately
        reset = 1'b0; in_tnew = 2'd0; in_src[31:0] = 32'h0000_1234;
        step();
        chk_main("rd_cap", 1'b1, 5'd8, 32'h1234, 2'd0);
        chk("rd_cap.pc", grf_pc, 32'h0000_3000);

        in_a3_mode = 2'd2; in_wd_sel = 2'd2; in_src[95:64] = 32'h0000_3008; in_pc = 32'h0000_3004;
        step();
        chk_main("link", 1'b1, 5'd31, 32'h3008, 2'd0);
        chk("link.pc", grf_pc, 32'h0000_3004);

        in_a3_mode = 2'd1; in_rd = 5'd0;
        step();
        chk_main("rd_zero", 1'b0, 5'd0, 32'h3008, 2'd0);

        in_a3_mode = 2'd3; in_rd = 5'd9;
        step();
        chk_main("nowrite", 1'b0, 5'd0, 32'h3008, 2'd0);

        in_a3_mode = 2'd0; in_rt = 5'd6; in_valid = 1'b0;
        step();
        chk_main("invalid", 1'b0, 5'd0, 32'h3008, 2'd0);

        // stall countdown: Tnew 2 -> 1 -> 0 -> 0 while destination stays visible
        in_valid = 1'b1; in_rt = 5'd5; in_tnew = 2'd2; in_wd_sel = 2'd1; in_src[63:32] = 32'h0000_BEEF;
        step();
        chk_main("stall0", 1'b0, 5'd5, 32'hBEEF, 2'd2);
        en = 1'b0; in_rt = 5'd9; in_tnew = 2'd3; in_src[63:32] = 32'h0000_DEAD;
        step();
        chk_main("stall1", 1'b0, 5'd5, 32'hBEEF, 2'd1);
        step();
        chk_main("stall2", 1'b1, 5'd5, 32'hBEEF, 2'd0);
        step();
        chk_main("stall3", 1'b1, 5'd5, 32'hBEEF, 2'd0);

        // flush wins over en
        en = 1'b1; flush = 1'b1; in_rt = 5'd7; in_tnew = 2'd0;
        step();
        chk_main("flush_en", 1'b0, 5'd0, 32'h0, 2'd0);
        chk("flush_en.pc", grf_pc, 32'h0);

        // flush during a stall drops the held instruction
        flush = 1'b0; in_tnew = 2'd2; in_src[63:32] = 32'h0000_0777;
        step();
        chk_main("fs_cap", 1'b0, 5'd7, 32'h0777, 2'd2);
        en = 1'b0;
        step();
        chk_main("fs_stall", 1'b0, 5'd7, 32'h0777, 2'd1);
        flush = 1'b1;
        step();
        chk_main("fs_flush", 1'b0, 5'd0, 32'h0, 2'd0);
        flush = 1'b0;
        step();
        chk_main("fs_after", 1'b0, 5'd0, 32'h0, 2'd0);

        // reset during a stall drops the held instruction
        en = 1'b1; in_tnew = 2'd1;
        step();
        chk_main("rs_cap", 1'b0, 5'd7, 32'h0777, 2'd1);
        en = 1'b0; reset = 1'b1;
        step();
        chk_main("rs_reset", 1'b0, 5'd0, 32'h0, 2'd0);
        reset = 1'b0;

        // out-of-range select on the 3-source instance
        en = 1'b1; in_a3_mode = 2'd1; in_rd = 5'd4; in_wd_sel = 2'd3; in_tnew = 2'd0;
        in_src[127:96] = 32'h5555_AAAA;
        step();
        chk("oor.wd3", grf_wd3, 32'h0);
        chk("oor.we3", 32'(grf_we3), 32'h1);
        chk("oor.a33", 32'(grf_a33), 32'd4);
        chk("oor.fdata3", fwd_data3, 32'h0);
        chk_main("oor.main", 1'b1, 5'd4, 32'h5555_AAAA, 2'd0);

        in_wd_sel = 2'd2;
        step();
        chk("sel2.wd3", grf_wd3, 32'hCCCC_0003);
        chk("sel2.we3", 32'(grf_we3), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
